// File: rtl/minterm_lut_seq_pkg.sv
// Shared types and defaults for the programmable sum-of-minterms evaluator.
package minterm_lut_seq_pkg;
  localparam int N_IN_DEF = 3;
  localparam int D        = 1 << N_IN_DEF;
  localparam logic [D-1:0] INIT_DEF = 8'hCE;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;
endpackage

// File: rtl/minterm_lut_seq_if.sv
// Lookup, result and serial-configuration signals of minterm_lut_seq.
interface minterm_lut_seq_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
);
  localparam int DW = 1 << N_IN;

  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic             out_f;
  logic [DW-1:0]    out_onehot;
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_done;
  logic [CNT_W-1:0] true_cnt;

  modport master (
    output in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
    input  in_ready, out_valid, out_f, out_onehot, cfg_done, true_cnt
  );
  modport slave (
    input  in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
    output in_ready, out_valid, out_f, out_onehot, cfg_done, true_cnt
  );
endinterface

// File: rtl/minterm_onehot_dec.sv
// Combinational N_IN-to-2^N_IN one-hot decoder.
module minterm_onehot_dec #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0]      sel,
  output logic [(1<<N_IN)-1:0] onehot
);
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/minterm_lut_seq.sv
// Registered truth-table lookup with one-hot decode, serial table reload
// and a saturating count of true results.
module minterm_lut_seq
  import minterm_lut_seq_pkg::*;
#(
  parameter int                  N_IN  = N_IN_DEF,
  parameter logic [(1<<N_IN)-1:0] INIT = INIT_DEF,
  parameter int                  CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  minterm_lut_seq_if.slave  bus
);
  localparam int DW = 1 << N_IN;

  state_t           state, state_nx;
  logic [N_IN-1:0]  idx;
  logic [DW-1:0]    tbl, idx_oh, vec_oh;
  logic             wr, last_wr, accept, out_hs;
  logic             out_valid, out_f, cfg_done;
  logic [DW-1:0]    out_onehot;
  logic [CNT_W-1:0] true_cnt;

  minterm_onehot_dec #(.N_IN(N_IN)) u_dec_vec (.sel(bus.in_vec), .onehot(vec_oh));
  minterm_onehot_dec #(.N_IN(N_IN)) u_dec_idx (.sel(idx),        .onehot(idx_oh));

  assign bus.in_ready = (state == RUN) && !bus.cfg_start && (!out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid && bus.out_ready;

  // cfg_start wins over cfg_valid in LOAD: the restart cycle writes nothing
  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    last_wr  = 1'b0;
    case (state)
      RUN:  if (bus.cfg_start) state_nx = LOAD;
      LOAD: if (!bus.cfg_start && bus.cfg_valid) begin
        wr = 1'b1;
        if (idx == '1) begin
          last_wr  = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      idx      <= '0;
      tbl      <= INIT;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nx;
      cfg_done <= last_wr;
      if (bus.cfg_start)          idx <= '0;
      else if (wr && !last_wr)    idx <= idx + 1'b1;
      if (wr) tbl <= (tbl & ~idx_oh) | ({DW{bus.cfg_bit}} & idx_oh);
    end
  end

  // result register holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_f      <= 1'b0;
      out_onehot <= '0;
      true_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_f      <= tbl[bus.in_vec];
        out_onehot <= vec_oh;
      end else if (bus.out_ready) begin
        out_valid  <= 1'b0;
      end
      if (out_hs && out_f && (true_cnt != '1)) true_cnt <= true_cnt + 1'b1;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_f      = out_f;
  assign bus.out_onehot = out_onehot;
  assign bus.cfg_done   = cfg_done;
  assign bus.true_cnt   = true_cnt;
endmodule

// File: doc/minterm_lut_seq.md
# minterm_lut_seq

Registered, run-time programmable sum-of-minterms evaluator. Takes an N_IN-bit input vector and returns the registered one-hot decode and the Boolean function value looked up from a 2^N_IN-bit truth table, with a valid/ready handshake on both sides. The truth table is reloaded serially through a configuration port, and a saturating counter tracks true results. It replaces fixed gate-level decoder-plus-OR function blocks in the logic-design exercise datapath.

## Interface
Parameters:
- N_IN, 3, input vector width; table depth D = 2^N_IN
- INIT, 8'hCE, reset truth table, D bits; bit k is f for minterm k (default true for minterms 1,2,3,6,7)
- CNT_W, 8, width of the true-result counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input this cycle
- in_vec  in  N_IN  input vector (minterm index)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_f  out  1  function value table[in_vec]
- out_onehot  out  D  registered decode, bit in_vec set
- cfg_start  in  1  pulse: begin table reload
- cfg_valid  in  1  cfg_bit valid
- cfg_bit  in  1  next truth-table bit, minterm 0 first
- cfg_done  out  1  one-cycle pulse after last bit is written
- true_cnt  out  CNT_W  saturating count of accepted results with out_f=1

## Operation
- FSM states: RUN and LOAD. Reset state RUN.
- RUN -> LOAD on cfg_start. The bit index clears to 0.
- LOAD: each cycle with cfg_valid high, table[idx] <= cfg_bit and idx increments.
  - When idx = D-1 is written, return to RUN and pulse cfg_done in the next cycle.
  - idx does not wrap.
- cfg_start in LOAD restarts the load with idx = 0. Already-written bits stay until overwritten.
- cfg_start in LOAD has priority over cfg_valid in the same cycle. That cfg_valid is ignored.
- in_ready = (state==RUN) && !cfg_start && (!out_valid || out_ready).
- On in_valid && in_ready, capture the following, and set out_valid:
  - out_f <= table[in_vec]
  - out_onehot <= 1<<in_vec
- out_valid clears on out_ready when no new input is accepted. Outputs hold stable while out_valid && !out_ready.
- A pending result is unaffected by entering LOAD. It reflects the table at capture time.
- true_cnt increments on each output handshake (out_valid && out_ready) with out_f=1. It saturates at 2^CNT_W-1.
- Reset values:
  - table = INIT
  - out_valid = 0, out_f = 0, out_onehot = 0
  - cfg_done = 0, true_cnt = 0
  - state RUN, idx = 0
- Reset mid-load discards the partial load. The table returns to INIT.

## Timing
- Input-to-result latency: 1 cycle. out_valid rises on the edge that accepts the input.
- Throughput: 1 result/cycle while out_ready is held high.
- Load of D bits takes at least D cycles. in_ready is low from the cycle cfg_start is high until the cycle after the last bit.
- cfg_done is high for exactly one cycle, coincident with the first cycle back in RUN.
- An input accepted in the first RUN cycle sees the new table.
- Reset is asynchronous assert. Deassertion is assumed synchronised upstream.

## Structure
- A shared package holds:
  - the state enum (RUN, LOAD)
  - the localparam D = 1<<N_IN
  - the default INIT constant
- One natural sub-module: minterm_onehot_dec, a combinational N_IN-to-D decoder. It drives out_onehot before the register and is also reused to form the table write-enable from idx.

## Test plan
- Reset, no load, N_IN=3. Apply in_vec 0..7 with out_ready=1 -> out_f = 0,1,1,1,0,0,1,1 and out_onehot = 8'h01..8'h80. After the 8 handshakes, true_cnt=5.
- Serial load of 8'h81, bit0 first (1,0,0,0,0,0,0,1) -> cfg_done pulses once, 8 cycles after the first cfg_valid. Then in_vec 7 -> out_f=1 and in_vec 3 -> out_f=0. in_ready is 0 throughout the load.
- Backpressure: hold out_ready=0 after accepting in_vec=2 -> out_valid stays 1, out_f=1 and out_onehot=8'h04 are stable, and in_ready=0. Release -> one handshake, and true_cnt +1 only once.
- cfg_start asserted again after 4 bits, then 8 fresh bits -> the table equals the fresh 8 bits. cfg_start together with in_valid -> the input is not accepted.
- Assert rst_n=0 after 3 load bits -> table=8'hCE, state RUN, and all outputs are zero. The next in_vec=6 gives out_f=1.
- CNT_W=2: six true results -> true_cnt saturates at 3.
